// File: rtl/serial_sub.sv
`default_nettype none
// ============================================================================
//  Module   : serial_sub
//  Purpose  : Bit-serial unsigned subtractor. Computes A - B modulo 2^WIDTH
//             one bit per clock, LSB first, and reports the final borrow.
//  Ports    : CLK    - clock, all state updates on the rising edge
//             Reset  - asynchronous, active-high reset
//             Start  - begin a subtraction (accepted only when idle)
//             A, B   - minuend / subtrahend, captured when Start is accepted
//             Diff   - registered result, updated only on completion
//             Bout   - registered final borrow (1 when A < B)
//             Busy   - high for the WIDTH cycles of bit-serial computation
//             Done   - one-cycle pulse when Diff/Bout hold a new result
//  Revision : 1.0 - initial release
// ============================================================================
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
  output logic             Busy,
  output logic             Done
);

  // Counter must be able to represent WIDTH itself.
  localparam int                c_CW   = $clog2(WIDTH + 1);
  localparam logic [c_CW-1:0]   c_LAST = c_CW'(WIDTH - 1);
  localparam logic [c_CW-1:0]   c_ONE  = c_CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_br;
  logic [c_CW-1:0]  r_cnt;

  logic             w_d;
  logic             w_br_next;
  logic             w_last;
  logic [WIDTH-1:0] w_res_next;

  // Full-subtractor on the current LSBs.
  assign w_d        = r_a[0] ^ r_b[0] ^ r_br;
  assign w_br_next  = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
  assign w_res_next = {w_d, r_res[WIDTH-1:1]};
  // The counter still holds WIDTH-1 on the final RUN edge.
  assign w_last     = (r_cnt == c_LAST);

  assign Busy = (r_state == S_RUN);
  assign Done = (r_state == S_DONE);

  // State register
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (Start)  w_state_next = S_RUN;
      S_RUN:   if (w_last) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Datapath. Diff/Bout are written only on the final RUN edge so the
  // partially assembled result in r_res is never visible.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_a   <= '0;
      r_b   <= '0;
      r_res <= '0;
      r_br  <= 1'b0;
      r_cnt <= '0;
      Diff  <= '0;
      Bout  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_a   <= A;
            r_b   <= B;
            r_br  <= 1'b0;
            r_cnt <= '0;
          end
        end
        S_RUN: begin
          r_res <= w_res_next;
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_br  <= w_br_next;
          r_cnt <= r_cnt + c_ONE;
          if (w_last) begin
            Diff <= w_res_next;
            Bout <= w_br_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_sub.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_sub
//  Purpose  : Self-checking bench for serial_sub (WIDTH = 8) using a table of
//             directed vectors plus hand-written multi-cycle sequences.
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
module tb_serial_sub;

  localparam int c_W = 8;

  logic           CLK;
  logic           Reset;
  logic           Start;
  logic [c_W-1:0] A;
  logic [c_W-1:0] B;
  logic [c_W-1:0] Diff;
  logic           Bout;
  logic           Busy;
  logic           Done;

  int  n_tests;
  int  n_fail;
  time last_done_t;

  serial_sub #(.WIDTH(c_W)) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .Start (Start),
    .A     (A),
    .B     (B),
    .Diff  (Diff),
    .Bout  (Bout),
    .Busy  (Busy),
    .Done  (Done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [c_W-1:0] a;
    logic [c_W-1:0] b;
    logic [c_W-1:0] diff;
    logic           bout;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Caller sits at a falling edge; Start is driven immediately so it is
  // accepted on the next rising edge. Returns at the falling edge of the
  // idle cycle following Done, so a back-to-back call starts right away.
  // inj > 0 pulses a foreign Start (9 - 9) during that RUN cycle.
  task automatic run_op(input string tag, input logic [c_W-1:0] a, input logic [c_W-1:0] b,
                        input logic [c_W-1:0] ed, input logic eb, input int inj);
    int             lat;
    int             busy_cnt;
    bit             changed;
    logic [c_W-1:0] prev;
    prev     = Diff;
    lat      = 0;
    busy_cnt = 0;
    changed  = 1'b0;
    Start = 1'b1;
    A     = a;
    B     = b;
    for (int k = 1; k <= 30; k++) begin
      @(negedge CLK);
      if (Done) begin
        lat = k;
        last_done_t = $time;
        break;
      end
      if (Busy) busy_cnt++;
      if (Diff !== prev) changed = 1'b1;
      Start = (inj > 0 && k == inj);
      if (Start) begin
        A = 8'd9;
        B = 8'd9;
      end
    end
    Start = 1'b0;
    check({tag, " latency"}, lat, c_W + 1);
    check({tag, " busy cycles"}, busy_cnt, c_W);
    check({tag, " no partial diff"}, {31'd0, changed}, 32'd0);
    check({tag, " diff"}, Diff, ed);
    check({tag, " bout"}, Bout, eb);
    @(negedge CLK);
    check({tag, " done one cycle"}, {Done, Busy}, 2'b00);
    check({tag, " diff held"}, Diff, ed);
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    last_done_t = 0;

    vecs[0] = '{8'h05, 8'h03, 8'h02, 1'b0};
    vecs[1] = '{8'h03, 8'h05, 8'hFE, 1'b1};
    vecs[2] = '{8'h00, 8'h00, 8'h00, 1'b0};
    vecs[3] = '{8'hFF, 8'h01, 8'hFE, 1'b0};
    vecs[4] = '{8'h00, 8'hFF, 8'h01, 1'b1};
    vecs[5] = '{8'h80, 8'h01, 8'h7F, 1'b0};
    vecs[6] = '{8'h7F, 8'h80, 8'hFF, 1'b1};

    Reset = 1'b1;
    Start = 1'b0;
    A     = '0;
    B     = '0;
    #12;
    check("reset outputs", {Diff, Bout, Busy, Done}, 11'd0);
    @(negedge CLK);
    Reset = 1'b0;

    // Directed table
    for (int i = 0; i < 7; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].diff, vecs[i].bout, 0);
      @(negedge CLK);
    end

    // Start pulsed mid-RUN must be ignored
    run_op("ignore", 8'd5, 8'd3, 8'h02, 1'b0, 3);
    @(negedge CLK);

    // Asynchronous reset during RUN cycle 4
    begin
      bit saw_done;
      saw_done = 1'b0;
      Start = 1'b1;
      A     = 8'd5;
      B     = 8'd3;
      for (int k = 1; k <= 4; k++) begin
        @(negedge CLK);
        Start = 1'b0;
      end
      check("abort busy before reset", {31'd0, Busy}, 32'd1);
      #2;
      Reset = 1'b1;
      #1;
      check("abort outputs cleared", {Diff, Bout, Busy, Done}, 11'd0);
      for (int k = 0; k < 3; k++) begin
        @(negedge CLK);
        if (Done) saw_done = 1'b1;
      end
      Reset = 1'b0;
      run_op("after reset", 8'd7, 8'd2, 8'h05, 1'b0, 0);
      for (int k = 0; k < 3; k++) begin
        if (Done) saw_done = 1'b1;
        @(negedge CLK);
      end
      check("abort no stray done", {31'd0, saw_done}, 32'd0);
    end

    // Back-to-back: second Start in the cycle after Done
    begin
      time t1;
      run_op("b2b first", 8'd10, 8'd4, 8'h06, 1'b0, 0);
      t1 = last_done_t;
      run_op("b2b second", 8'd4, 8'd10, 8'hFA, 1'b1, 0);
      check("b2b spacing", 32'(last_done_t - t1), 32'((c_W + 2) * 10));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
